// File: rtl/rx_source_pkg.sv
// Shared definitions for the RX source selector: mode encodings and
// field positions inside the mode settings word.
package rx_source_pkg;

    typedef enum logic [1:0] {
        MODE_NORMAL   = 2'd0,
        MODE_LOOPBACK = 2'd1,
        MODE_COUNTER  = 2'd2,
        MODE_CONSTANT = 2'd3
    } mode_t;

    localparam int MODE_LSB = 0;
    localparam int MODE_W   = 2;
    localparam int CLR_BIT  = 2;
    localparam int PAT_LSB  = 16;
    localparam int PAT_W    = 16;

endpackage

// File: rtl/setting_reg.sv
// Generic serial-settings-bus register: latches its input when the bus
// strobe hits the configured address.
module setting_reg #(
    parameter logic [6:0]       ADDR     = 7'd0,
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] AT_RESET = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             strobe,
    input  logic [6:0]       addr,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out
);

    // Capture the bus word on an addressed write.
    always_ff @(posedge clock) begin
        if (reset)
            out <= AT_RESET;
        else if (strobe && (addr == ADDR))
            out <= in;
    end

endmodule

// File: rtl/rx_source_mux.sv
// Receive-path source selector: per channel picks the DDC sample, a
// captured TX loopback word, a debug counter or a constant pattern, and
// registers the result with a one-cycle valid strobe.
module rx_source_mux
    import rx_source_pkg::*;
#(
    parameter int         NCHAN = 8,
    parameter int         NTX   = 4,
    parameter int         WIDTH = 16,
    parameter logic [6:0] ADDR  = 7'd38
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   serial_strobe,
    input  logic [6:0]             serial_addr,
    input  logic [31:0]            serial_data,
    input  logic                   rx_strobe,
    input  logic [NCHAN*WIDTH-1:0] rx_in,
    input  logic                   tx_strobe,
    input  logic [NTX*WIDTH-1:0]   tx_in,
    output logic [NCHAN*WIDTH-1:0] ch_out,
    output logic                   ch_valid,
    output logic [31:0]            sample_count
);

    localparam int SET_W = PAT_W + MODE_W;

    logic [SET_W-1:0] set_word;
    logic [SET_W-1:0] set_q;
    logic             set_hit;
    logic             clr;
    logic             take;
    mode_t            mode;
    logic [WIDTH-1:0] pattern;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cap_q [NTX];
    logic [WIDTH-1:0] out_q [NCHAN];
    logic             unused_data;

    // Only mode and pattern are stored; clr acts on the write strobe itself.
    assign set_word    = {serial_data[PAT_LSB +: PAT_W], serial_data[MODE_LSB +: MODE_W]};
    assign unused_data = ^serial_data[PAT_LSB-1:CLR_BIT+1];
    assign set_hit     = serial_strobe && (serial_addr == ADDR);
    assign clr         = set_hit && serial_data[CLR_BIT];
    assign take        = rx_strobe && enable;

    setting_reg #(
        .ADDR     (ADDR),
        .WIDTH    (SET_W),
        .AT_RESET ('0)
    ) u_mode_reg (
        .clock  (clock),
        .reset  (reset),
        .strobe (serial_strobe),
        .addr   (serial_addr),
        .in     (set_word),
        .out    (set_q)
    );

    assign mode    = mode_t'(set_q[MODE_W-1:0]);
    assign pattern = WIDTH'(set_q[SET_W-1:MODE_W]);

    genvar j, k;

    // Loopback capture: latch every TX word on its strobe, regardless of enable.
    generate
        for (j = 0; j < NTX; j++) begin : g_cap
            always_ff @(posedge clock) begin
                if (reset)
                    cap_q[j] <= '0;
                else if (tx_strobe)
                    cap_q[j] <= tx_in[j*WIDTH +: WIDTH];
            end
        end
    endgenerate

    // Output stage: per-channel 4-way source selection, loaded on accepted strobes.
    generate
        for (k = 0; k < NCHAN; k++) begin : g_out
            always_ff @(posedge clock) begin
                if (reset)
                    out_q[k] <= '0;
                else if (take) begin
                    case (mode)
                        MODE_NORMAL:   out_q[k] <= rx_in[k*WIDTH +: WIDTH];
                        MODE_LOOPBACK: out_q[k] <= cap_q[k % NTX];
                        MODE_COUNTER:  out_q[k] <= cnt + WIDTH'(k);
                        MODE_CONSTANT: out_q[k] <= ((k % 2) == 0) ? pattern : ~pattern;
                        default:       out_q[k] <= rx_in[k*WIDTH +: WIDTH];
                    endcase
                end
            end
            assign ch_out[k*WIDTH +: WIDTH] = out_q[k];
        end
    endgenerate

    // Counter base: cleared by enable low or clr, which win over the advance.
    always_ff @(posedge clock) begin
        if (reset || !enable || clr)
            cnt <= '0;
        else if (rx_strobe)
            cnt <= cnt + WIDTH'(NCHAN);
    end

    // Accepted-sample count for readback; clr wins over the increment.
    always_ff @(posedge clock) begin
        if (reset || clr)
            sample_count <= '0;
        else if (take)
            sample_count <= sample_count + 32'd1;
    end

    // One-cycle valid pulse following each accepted strobe.
    always_ff @(posedge clock) begin
        if (reset)
            ch_valid <= 1'b0;
        else
            ch_valid <= take;
    end

endmodule

// File: tb/tb_rx_source_mux.sv
// Self-checking bench for rx_source_mux: directed scenarios with literal
// expectations, then randomized traffic, all compared every cycle
// against a behavioural model of the selector.
module tb_rx_source_mux;

    localparam int NCHAN = 8;
    localparam int NTX   = 4;
    localparam int WIDTH = 16;
    localparam logic [6:0] ADDR = 7'd38;

    logic                   clock = 1'b0;
    logic                   reset;
    logic                   enable;
    logic                   serial_strobe;
    logic [6:0]             serial_addr;
    logic [31:0]            serial_data;
    logic                   rx_strobe;
    logic [NCHAN*WIDTH-1:0] rx_in;
    logic                   tx_strobe;
    logic [NTX*WIDTH-1:0]   tx_in;
    logic [NCHAN*WIDTH-1:0] ch_out;
    logic                   ch_valid;
    logic [31:0]            sample_count;

    int n_cmp  = 0;
    int n_fail = 0;

    rx_source_mux #(
        .NCHAN (NCHAN),
        .NTX   (NTX),
        .WIDTH (WIDTH),
        .ADDR  (ADDR)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
        .serial_strobe (serial_strobe),
        .serial_addr   (serial_addr),
        .serial_data   (serial_data),
        .rx_strobe     (rx_strobe),
        .rx_in         (rx_in),
        .tx_strobe     (tx_strobe),
        .tx_in         (tx_in),
        .ch_out        (ch_out),
        .ch_valid      (ch_valid),
        .sample_count  (sample_count)
    );

    always #5 clock = ~clock;

    // ---------------- behavioural model ----------------
    int  m_out [NCHAN];
    int  m_cap [NTX];
    int  m_cnt;
    int  m_pat;
    int  m_mode;
    longint m_sc;
    bit  m_valid;
    bit  m_live = 0;

    always @(posedge clock) begin
        bit wr_hit;
        bit do_clr;
        wr_hit = serial_strobe && (serial_addr == ADDR);
        do_clr = wr_hit && serial_data[2];
        if (reset) begin
            foreach (m_out[i]) m_out[i] = 0;
            foreach (m_cap[i]) m_cap[i] = 0;
            m_cnt = 0; m_pat = 0; m_mode = 0; m_sc = 0; m_valid = 0;
            m_live = 1;
        end else begin
            m_valid = rx_strobe && enable;
            if (m_valid) begin
                for (int i = 0; i < NCHAN; i++) begin
                    case (m_mode)
                        0: m_out[i] = int'(rx_in[i*WIDTH +: WIDTH]);
                        1: m_out[i] = m_cap[i % NTX];
                        2: m_out[i] = (m_cnt + i) % 65536;
                        default: m_out[i] = (i % 2 == 0) ? m_pat : (65535 - m_pat);
                    endcase
                end
            end
            if (!enable || do_clr) m_cnt = 0;
            else if (rx_strobe)    m_cnt = (m_cnt + NCHAN) % 65536;
            if (do_clr)       m_sc = 0;
            else if (m_valid) m_sc = (m_sc + 1) % 64'h1_0000_0000;
            if (tx_strobe)
                for (int i = 0; i < NTX; i++) m_cap[i] = int'(tx_in[i*WIDTH +: WIDTH]);
            if (wr_hit) begin
                m_mode = int'(serial_data[1:0]);
                m_pat  = int'(serial_data[31:16]);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare the DUT against the model every cycle once reset has been seen.
    always @(negedge clock) begin
        if (m_live) begin
            chk("ch_valid", {31'd0, ch_valid}, {31'd0, m_valid});
            chk("sample_count", sample_count, m_sc[31:0]);
            for (int i = 0; i < NCHAN; i++)
                chk($sformatf("ch_out[%0d]", i), {16'd0, ch_out[i*WIDTH +: WIDTH]}, m_out[i]);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(negedge clock);
    endtask

    function automatic logic [15:0] word(input int k);
        return ch_out[k*WIDTH +: WIDTH];
    endfunction

    task automatic wr(input logic [31:0] d);
        serial_strobe = 1'b1; serial_addr = ADDR; serial_data = d;
        cyc();
        serial_strobe = 1'b0;
    endtask

    task automatic strobe_rx();
        rx_strobe = 1'b1;
        cyc();
        rx_strobe = 1'b0;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1;
        serial_strobe = 1'b0; serial_addr = 7'd0; serial_data = 32'd0;
        rx_strobe = 1'b0; tx_strobe = 1'b0;
        rx_in = '0; tx_in = '0;
        repeat (3) cyc();
        reset = 1'b0;
        cyc();
        chk("reset ch_valid", {31'd0, ch_valid}, 32'd0);
        chk("reset ch_out0", {16'd0, word(0)}, 32'd0);
        chk("reset sample_count", sample_count, 32'd0);

        // NORMAL
        for (int i = 0; i < NCHAN; i++) rx_in[i*WIDTH +: WIDTH] = 16'h1000 + 16'(i);
        strobe_rx();
        chk("normal valid", {31'd0, ch_valid}, 32'd1);
        chk("normal ch0", {16'd0, word(0)}, 32'h1000);
        chk("normal ch7", {16'd0, word(7)}, 32'h1007);
        cyc();
        chk("normal valid drop", {31'd0, ch_valid}, 32'd0);
        chk("normal hold ch3", {16'd0, word(3)}, 32'h1003);

        // COUNTER, back-to-back strobes
        wr(32'h0000_0006);
        rx_strobe = 1'b1;
        cyc();
        chk("cnt s1 ch1", {16'd0, word(1)}, 32'd1);
        chk("cnt s1 ch7", {16'd0, word(7)}, 32'd7);
        cyc();
        chk("cnt s2 ch7", {16'd0, word(7)}, 32'd15);
        cyc();
        rx_strobe = 1'b0;
        chk("cnt s3 ch0", {16'd0, word(0)}, 32'd16);
        chk("cnt s3 sample_count", sample_count, 32'd3);

        // COUNTER wrap: base reaches 16'hFFF8 on the 8192nd strobe after clr
        wr(32'h0000_0006);
        rx_strobe = 1'b1;
        repeat (8191) cyc();
        cyc();
        chk("wrap ch0", {16'd0, word(0)}, 32'hFFF8);
        chk("wrap ch7", {16'd0, word(7)}, 32'hFFFF);
        cyc();
        rx_strobe = 1'b0;
        chk("wrap next ch0", {16'd0, word(0)}, 32'h0000);
        chk("wrap next ch5", {16'd0, word(5)}, 32'h0005);

        // clr coinciding with a strobe at cnt = 40
        wr(32'h0000_0006);
        repeat (5) strobe_rx();
        serial_strobe = 1'b1; serial_addr = ADDR; serial_data = 32'h0000_0006;
        rx_strobe = 1'b1;
        cyc();
        serial_strobe = 1'b0; rx_strobe = 1'b0;
        chk("clr ch0 pre-clear", {16'd0, word(0)}, 32'd40);
        chk("clr ch1 pre-clear", {16'd0, word(1)}, 32'd41);
        strobe_rx();
        chk("clr next ch0", {16'd0, word(0)}, 32'd0);
        chk("clr next sample_count", sample_count, 32'd1);

        // LOOPBACK
        tx_in[0*WIDTH +: WIDTH] = 16'hA0A0;
        tx_in[1*WIDTH +: WIDTH] = 16'hB1B1;
        tx_in[2*WIDTH +: WIDTH] = 16'hC2C2;
        tx_in[3*WIDTH +: WIDTH] = 16'hD3D3;
        tx_strobe = 1'b1; cyc(); tx_strobe = 1'b0;
        wr(32'h0000_0001);
        strobe_rx();
        chk("loop ch0", {16'd0, word(0)}, 32'hA0A0);
        chk("loop ch3", {16'd0, word(3)}, 32'hD3D3);
        chk("loop ch5", {16'd0, word(5)}, 32'hB1B1);
        chk("loop ch6", {16'd0, word(6)}, 32'hC2C2);
        tx_in[0*WIDTH +: WIDTH] = 16'h0E0E;
        tx_strobe = 1'b1; rx_strobe = 1'b1;
        cyc();
        tx_strobe = 1'b0; rx_strobe = 1'b0;
        chk("loop same-cycle ch0 old", {16'd0, word(0)}, 32'hA0A0);
        strobe_rx();
        chk("loop next ch4 new", {16'd0, word(4)}, 32'h0E0E);

        // CONSTANT, then a same-cycle write uses the old mode
        wr(32'h5A5A_0003);
        strobe_rx();
        chk("const ch0", {16'd0, word(0)}, 32'h5A5A);
        chk("const ch1", {16'd0, word(1)}, 32'hA5A5);
        serial_strobe = 1'b1; serial_addr = ADDR; serial_data = 32'h0000_0000;
        rx_strobe = 1'b1;
        cyc();
        serial_strobe = 1'b0;
        chk("write same-cycle ch1 old mode", {16'd0, word(1)}, 32'hA5A5);
        cyc();
        rx_strobe = 1'b0;
        chk("write next ch1 new mode", {16'd0, word(1)}, 32'h1001);

        // enable low during continuous strobes, then restart in COUNTER
        wr(32'h0000_0002);
        rx_strobe = 1'b1;
        repeat (2) cyc();
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("enable low valid", {31'd0, ch_valid}, 32'd0);
        end
        enable = 1'b1;
        cyc();
        chk("enable rise valid", {31'd0, ch_valid}, 32'd1);
        chk("enable rise ch0", {16'd0, word(0)}, 32'd0);
        chk("enable rise ch3", {16'd0, word(3)}, 32'd3);

        // reset mid-stream
        reset = 1'b1;
        cyc();
        chk("midreset valid", {31'd0, ch_valid}, 32'd0);
        chk("midreset ch0", {16'd0, word(0)}, 32'd0);
        chk("midreset sample_count", sample_count, 32'd0);
        reset = 1'b0;
        cyc();
        rx_strobe = 1'b0;
        chk("after reset normal ch2", {16'd0, word(2)}, 32'h1002);

        // randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            reset         = ($urandom_range(0, 299) == 0);
            enable        = ($urandom_range(0, 9) != 0);
            rx_strobe     = $urandom_range(0, 1);
            tx_strobe     = ($urandom_range(0, 2) == 0);
            serial_strobe = ($urandom_range(0, 7) == 0);
            serial_addr   = ($urandom_range(0, 3) == 0) ? 7'($urandom) : ADDR;
            serial_data   = $urandom;
            if ($urandom_range(0, 3) != 0) serial_data[2] = 1'b0;
            for (int i = 0; i < NCHAN; i++) rx_in[i*WIDTH +: WIDTH] = 16'($urandom);
            for (int i = 0; i < NTX; i++)   tx_in[i*WIDTH +: WIDTH] = 16'($urandom);
            cyc();
        end
        reset = 1'b0; rx_strobe = 1'b0; tx_strobe = 1'b0; serial_strobe = 1'b0;
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/rx_source_mux.md
# rx_source_mux

Parametrised receive-path source selector between the DDC chains and `rx_buffer`. It generalises the fixed two-channel loopback/counter selection to NCHAN channels. Each sample is taken from the DDC output, from TX loopback, from a debug counter or from a constant pattern. The mode is programmed over the serial settings bus, and all outputs are registered and qualified by a valid strobe.

## Interface
- NCHAN, 8: number of RX channels; even, 2..16.
- NTX, 4: number of TX baseband channels available for loopback; 1..8.
- WIDTH, 16: sample width in bits.
- ADDR, 7'd38: serial settings address of the mode register.

Ports:
- `clock`  in  1: single clock, the 64 MHz master clock. One clock; reset is synchronous and active-high.
- `reset`  in  1: synchronous, active-high.
- `enable`  in  1: RX enable. While low, the counter is held at 0 and `ch_valid` is 0.
- `serial_strobe`  in  1: settings write strobe.
- `serial_addr`  in  7: settings address.
- `serial_data`  in  32: settings data.
- `rx_strobe`  in  1: DDC output sample strobe (hb_strobe).
- `rx_in`  in  NCHAN*WIDTH: DDC samples; channel k occupies bits [k*WIDTH +: WIDTH].
- `tx_strobe`  in  1: TX interpolator strobe.
- `tx_in`  in  NTX*WIDTH: TX baseband samples, packed the same way as `rx_in`.
- `ch_out`  out  NCHAN*WIDTH: selected samples, registered.
- `ch_valid`  out  1: one-cycle pulse marking new `ch_out`.
- `sample_count`  out  32: count of `rx_strobe` pulses accepted while enabled; intended for readback.

## Operation
- Mode register, written when `serial_strobe` is high and `serial_addr == ADDR`:
  - [1:0] mode: 0 = NORMAL, 1 = LOOPBACK, 2 = COUNTER, 3 = CONSTANT.
  - [2] clr: self-clearing; zeroes the counter and `sample_count`; the stored value of this bit is not retained.
  - [31:16] constant pattern value.
- Loopback capture: on each `tx_strobe`, all NTX `tx_in` words are latched into capture registers. Capture is independent of `enable`.
- Sample path: on `rx_strobe` with `enable` high, channel k is loaded as follows.
  - NORMAL: `rx_in[k]`.
  - LOOPBACK: capture register `k mod NTX`.
  - COUNTER: `cnt + k`, computed mod 2^WIDTH.
  - CONSTANT: pattern for even k, bitwise inverse of pattern for odd k.
- After loading, `cnt` advances by NCHAN (mod 2^WIDTH) and `sample_count` advances by 1 (wraps at 2^32).
- Counter base `cnt` is WIDTH bits. It is cleared by `reset`, by `enable` low, or by clr. It is not cleared by a mode change.
- No state machine beyond the mode register. Behaviour is a 4-way selection feeding one output register stage.

## Timing
- Reset values: `ch_out` = 0, `ch_valid` = 0, `sample_count` = 0, `cnt` = 0, mode = NORMAL, pattern = 0, capture registers = 0.
- Latency: an `rx_strobe` at cycle n updates `ch_out` at n+1 and pulses `ch_valid` at n+1 for exactly one cycle. `ch_out` holds between strobes.
- Settings write at cycle n takes effect for any `rx_strobe` at cycle n+1 or later. A strobe in cycle n itself uses the old mode.
- `tx_strobe` and `rx_strobe` in the same cycle: LOOPBACK outputs the previously captured values; the new capture is visible on the next `rx_strobe`.
- clr coinciding with `rx_strobe`: the output uses the pre-clear `cnt`; the next state of `cnt` and `sample_count` is 0 (clear wins over increment).
- `enable` low coinciding with `rx_strobe`: no output update and no valid pulse.
- `reset` asserted mid-stream: every register returns to its reset value on the next edge, and any pending `ch_valid` is suppressed.
- Back-to-back `rx_strobe` on consecutive cycles is supported at one sample set per cycle.

## Structure
- Shared package `rx_source_pkg`:
  - mode encodings MODE_NORMAL, MODE_LOOPBACK, MODE_COUNTER, MODE_CONSTANT;
  - field positions MODE_LSB, CLR_BIT, PAT_LSB.
- The mode register is the existing `setting_reg` instantiated with parameter ADDR. clr is decoded directly from the write strobe, so it is not stored.
- Capture and output registers use generate loops over NCHAN and NTX. No further sub-modules.

## Test plan
- Reset, then NORMAL with `rx_in[k] = 16'h1000 + k` and a strobe → `ch_out[k] = 16'h1000 + k` one cycle later, with a single `ch_valid` pulse.
- COUNTER, NCHAN = 8, three strobes → channel k reads k, then 8+k, then 16+k. Preload `cnt` = 16'hFFFC → channel 5 reads 16'h0001 (wrap).
- LOOPBACK, NTX = 4, `tx_in` = {A, B, C, D} captured → channels 0..7 read A B C D A B C D. Simultaneous new `tx_strobe` plus `rx_strobe` → old values.
- CONSTANT, pattern 16'h5A5A → even channels 16'h5A5A, odd channels 16'hA5A5. Write at cycle n plus strobe at n → old mode; strobe at n+1 → new mode.
- clr together with `rx_strobe` at `cnt` = 40 → output base 40; next strobe base 0 and `sample_count` = 1.
- `enable` low, or `reset` pulsed, during continuous strobes → no `ch_valid`, `cnt` = 0. After `enable` rises, COUNTER restarts at k.
